// File: rtl/lse_acc_ctrl.sv
// lse_acc_ctrl: sequences one lse_add stage over a vector of log-domain
// elements, accumulating the LSE sum and presenting it on an output handshake.
module lse_acc_ctrl #(
    parameter int WIDTH       = 24,
    parameter int VEC_LEN_MAX = 64,
    parameter int CNT_W       = $clog2(VEC_LEN_MAX + 1),
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_length,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_add_enable,
    output logic [WIDTH-1:0] o_add_a,
    output logic [WIDTH-1:0] o_add_b,
    output logic [1:0]       o_add_mode,
    input  logic [WIDTH-1:0] i_add_result,
    input  logic             i_add_valid,
    output logic             o_busy,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    input  logic             i_out_ready,
    output logic             o_error
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [WIDTH-1:0] NEG_INF  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(VEC_LEN_MAX);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic [TMR_W-1:0] timer;
    logic             add_enable;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             error;

    logic [CNT_W-1:0] len_clamped;
    logic [CNT_W-1:0] cnt_inc;
    logic             start_acc;
    logic             in_fire;
    logic             add_done;
    logic             timeout;

    assign len_clamped = (i_length > LEN_MAX) ? LEN_MAX : i_length;
    assign cnt_inc     = cnt + CNT_W'(1);

    // State register; reset aborts any reduction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state event strobes.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        in_fire   = 1'b0;
        add_done  = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_nxt = (len_clamped == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_in_valid) begin
                    in_fire   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_add_valid) begin
                    add_done  = 1'b1;
                    state_nxt = (cnt_inc == len) ? S_DONE : S_LOAD;
                end else if (timer == TMR_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulator, counters, adder operands and the sticky timeout flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc        <= NEG_INF;
            cnt        <= '0;
            len        <= '0;
            timer      <= '0;
            add_enable <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            error      <= 1'b0;
        end else begin
            add_enable <= in_fire;
            if (start_acc) begin
                len   <= len_clamped;
                acc   <= NEG_INF;
                cnt   <= '0;
                error <= 1'b0;
            end
            if (in_fire) begin
                add_a <= acc;
                add_b <= i_in_data;
                timer <= '0;
            end
            if (state == S_WAIT && !add_done) begin
                timer <= timer + TMR_W'(1);
            end
            if (add_done) begin
                acc <= i_add_result;
                cnt <= cnt_inc;
            end
            if (timeout) begin
                error <= 1'b1;
            end
        end
    end

    assign o_in_ready   = (state == S_LOAD);
    assign o_busy       = (state != S_IDLE);
    assign o_out_valid  = (state == S_DONE);
    assign o_out_data   = (state == S_DONE) ? acc : '0;
    assign o_add_enable = add_enable;
    assign o_add_a      = add_a;
    assign o_add_b      = add_b;
    assign o_add_mode   = 2'b00;
    assign o_error      = error;

endmodule
